// File: rtl/led_arb_pkg.sv
// led_arb_pkg: shared state type, LED width and round-robin pick for the LED bank arbiter
package led_arb_pkg;
  typedef enum logic [0:0] {IDLE, GRANT} led_arb_state_t;
  localparam int LED_W = 4;
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last, input int n);
    logic [2:0] w;
    logic [2:0] j;
    w = last;
    for (int k = n; k >= 1; k--) begin
      j = 3'((int'(last) + k) % n);
      if (req[j]) w = j;
    end
    return w;
  endfunction
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler emitting a one-cycle tick every TICK_DIV clocks, restartable by clr
module led_tick_gen
  import led_arb_pkg::*;
#(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick  = cnt_q == CW'(TICK_DIV - 1);
  assign cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  // count register, wraps after the tick and restarts on a new grant
  always_ff @(posedge clk) begin
    cnt_q <= reset ? '0 : cnt_d;
  end
endmodule

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin timed sharing of a 4-LED bank; optional idle blink via LED_ARB_IDLE_BLINK_EN
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TICK_DIV   = 25000000,
  parameter int HOLD_TICKS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [LED_W*NUM_REQ-1:0] pattern,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     done,
  output logic [LED_W-1:0]         led
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  led_arb_state_t state_q, state_d;
  logic [IW-1:0] last_q, last_d, pick;
  logic [HW-1:0] hold_q, hold_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic done_q, done_d;
  logic [LED_W-1:0] led_q, led_d, idle_led;
  logic [LED_W-1:0] pats [NUM_REQ];
  logic tick, clr, expire;
  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .tick (tick)
  );
  assign clr    = state_q == IDLE && |req;
  assign pick   = IW'(rr_pick(8'(req), 3'(last_q), NUM_REQ));
  assign expire = tick && (int'(hold_q) + 1 == HOLD_TICKS);
  // split the flat pattern bus into one LED word per requester
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) pats[i] = pattern[LED_W*i +: LED_W];
  end
`ifdef LED_ARB_IDLE_BLINK_EN
  logic tog_q, tog_d;
  assign tog_d    = (clr || state_q == GRANT) ? 1'b0 : tick ? ~tog_q : tog_q;
  assign idle_led = {{(LED_W-1){1'b0}}, tog_d};
  // idle blink toggle, held at 0 while the bank is owned
  always_ff @(posedge clk) begin
    tog_q <= reset ? 1'b0 : tog_d;
  end
`else
  assign idle_led = '0;
`endif
  // arbitration, grant expiry/release and LED source selection
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    led_d   = idle_led;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = GRANT;
        last_d  = pick;
        hold_d  = '0;
        grant_d = NUM_REQ'(1) << pick;
        led_d   = pats[pick];
      end
    end else if (!req[last_q] || expire) begin
      state_d = IDLE;
      grant_d = '0;
      done_d  = 1'b1;
    end else begin
      hold_d = tick ? hold_q + 1'b1 : hold_q;
      led_d  = pats[last_q];
    end
  end
  // state and output registers; reset gives requester 0 top priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      hold_q  <= '0;
      grant_q <= '0;
      done_q  <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end
  assign grant = grant_q;
  assign busy  = |grant_q;
  assign done  = done_q;
  assign led   = led_q;
endmodule
